// File: rtl/axi_mem_responder.sv
// AXI4 slave memory responder: one 512-bit beat per 64-byte line, INCR bursts
// with index wrap, WSTRB byte enables and a fixed read latency.
module axi_mem_responder #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 16,
  parameter int unsigned AXI_DATA_WIDTH = 512,
  parameter int unsigned MEM_LINES      = 4096,
  parameter int unsigned RD_LATENCY     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  // write address
  input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  // write data
  input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  // write response
  output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  // read address
  input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  // read data
  output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(MEM_LINES);
  localparam int unsigned LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_LINES];

  // Byte offset bits inside a line are never used for addressing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[OFF_W-1:0], s_axi_araddr[OFF_W-1:0]};

  // Out of range when any address bit above the backed line range is set.
  logic aw_err, ar_err;
  assign aw_err = |s_axi_awaddr[AXI_ADDR_WIDTH-1:OFF_W+IDX_W];
  assign ar_err = |s_axi_araddr[AXI_ADDR_WIDTH-1:OFF_W+IDX_W];

  // ---------------- write channel ----------------
  w_state_e                w_state_q, w_state_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [AXI_ID_WIDTH-1:0] bid_q, bid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [IDX_W-1:0]        widx_q, widx_d;
  logic [8:0]              wbeats_q, wbeats_d;
  logic                    werr_q, werr_d;
  logic                    wmism_q, wmism_d;
  logic                    mem_we;

  // Write FSM next-state: address latch, beat counting, response generation.
  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    widx_d    = widx_q;
    wbeats_d  = wbeats_q;
    werr_d    = werr_q;
    wmism_d   = wmism_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid && awready_q) begin
          w_state_d = W_DATA;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          bid_d     = s_axi_awid;
          widx_d    = s_axi_awaddr[OFF_W +: IDX_W];
          wbeats_d  = {1'b0, s_axi_awlen} + 9'd1;
          werr_d    = aw_err;
          wmism_d   = 1'b0;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid && wready_q) begin
          mem_we   = !werr_q;
          widx_d   = widx_q + IDX_W'(1);
          wbeats_d = wbeats_q - 9'd1;
          if (wbeats_q == 9'd1) begin
            w_state_d = W_RESP;
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (werr_q)                      bresp_d = RESP_DECERR;
            else if (wmism_q || !s_axi_wlast) bresp_d = RESP_SLVERR;
            else                             bresp_d = RESP_OKAY;
          end else if (s_axi_wlast) begin
            wmism_d = 1'b1;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      widx_q    <= '0;
      wbeats_q  <= '0;
      werr_q    <= 1'b0;
      wmism_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      widx_q    <= widx_d;
      wbeats_q  <= wbeats_d;
      werr_q    <= werr_d;
      wmism_q   <= wmism_d;
    end
  end

  // Line array byte-enable write; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem[widx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_e                r_state_q, r_state_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic                    rlast_q, rlast_d;
  logic [AXI_ID_WIDTH-1:0] rid_q, rid_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic [IDX_W-1:0]        ridx_q, ridx_d;
  logic [8:0]              rbeats_q, rbeats_d;
  logic                    rerr_q, rerr_d;
  logic [LAT_W-1:0]        lat_q, lat_d;
  logic                    rload;

  // Read FSM next-state: request latch, latency countdown, beat sequencing.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    ridx_d    = ridx_q;
    rbeats_d  = rbeats_q;
    rerr_d    = rerr_q;
    lat_d     = lat_q;
    rload     = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          r_state_d = R_WAIT;
          arready_d = 1'b0;
          rid_d     = s_axi_arid;
          ridx_d    = s_axi_araddr[OFF_W +: IDX_W];
          rbeats_d  = {1'b0, s_axi_arlen} + 9'd1;
          rerr_d    = ar_err;
          lat_d     = LAT_W'(RD_LATENCY - 1);
        end
      end
      R_WAIT: begin
        if (lat_q == '0) begin
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
          rlast_d   = (rbeats_q == 9'd1);
          rresp_d   = rerr_q ? RESP_DECERR : RESP_OKAY;
          rload     = 1'b1;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          if (rbeats_q == 9'd1) begin
            r_state_d = R_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
          end else begin
            rbeats_d = rbeats_q - 9'd1;
            ridx_d   = ridx_q + IDX_W'(1);
            rlast_d  = (rbeats_q == 9'd2);
            rload    = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM state register; rdata samples the array before any same-edge write lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      ridx_q    <= '0;
      rbeats_q  <= '0;
      rerr_q    <= 1'b0;
      lat_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      ridx_q    <= ridx_d;
      rbeats_q  <= rbeats_d;
      rerr_q    <= rerr_d;
      lat_q     <= lat_d;
      if (rload) rdata_q <= rerr_q ? '0 : mem[ridx_d];
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares on every handshake.
module tb_axi_mem_responder;
  localparam int unsigned AW = 64;
  localparam int unsigned IW = 16;
  localparam int unsigned DW = 512;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [IW-1:0] s_axi_awid = '0;
  logic [AW-1:0] s_axi_awaddr = '0;
  logic [7:0] s_axi_awlen = '0;
  logic s_axi_awvalid = 1'b0, s_axi_awready;
  logic [DW-1:0] s_axi_wdata = '0;
  logic [DW/8-1:0] s_axi_wstrb = '0;
  logic s_axi_wlast = 1'b0, s_axi_wvalid = 1'b0, s_axi_wready;
  logic [IW-1:0] s_axi_bid;
  logic [1:0] s_axi_bresp;
  logic s_axi_bvalid, s_axi_bready = 1'b1;
  logic [IW-1:0] s_axi_arid = '0;
  logic [AW-1:0] s_axi_araddr = '0;
  logic [7:0] s_axi_arlen = '0;
  logic s_axi_arvalid = 1'b0, s_axi_arready;
  logic [IW-1:0] s_axi_rid;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0] s_axi_rresp;
  logic s_axi_rlast, s_axi_rvalid, s_axi_rready = 1'b1;

  always #5 clk = ~clk;

  axi_mem_responder #(
    .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .AXI_DATA_WIDTH(DW),
    .MEM_LINES(4096), .RD_LATENCY(4)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  typedef struct { logic [IW-1:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t bq[$];
  r_exp_t rq[$];
  int tests = 0;
  int fails = 0;
  int rr_mode = 0;  // 0: rready high, 1: toggle every cycle, 2: held low

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int v);
    return {16{32'(v)}};
  endfunction

  task automatic push_b(input logic [IW-1:0] id, input logic [1:0] resp);
    b_exp_t e;
    e.id = id; e.resp = resp;
    bq.push_back(e);
  endtask

  task automatic push_r(input logic [IW-1:0] id, input logic [DW-1:0] data,
                        input logic [1:0] resp, input logic last);
    r_exp_t e;
    e.id = id; e.data = data; e.resp = resp; e.last = last;
    rq.push_back(e);
  endtask

  // Monitor: compare every B/R handshake, and check R holds steady across stalls.
  logic r_stall = 1'b0;
  logic [DW-1:0] snap_data;
  logic [19:0] snap_ctl;
  initial begin
    b_exp_t be;
    r_exp_t re;
    forever begin
      @(negedge clk);
      if (reset) begin
        r_stall = 1'b0;
      end else begin
        if (s_axi_bvalid && s_axi_bready) begin
          if (bq.size() == 0) begin
            tests++; fails++;
            $display("FAIL b_unexpected: got bid %0h bresp %0b, required no response", s_axi_bid, s_axi_bresp);
          end else begin
            be = bq.pop_front();
            chk("bid", DW'(s_axi_bid), DW'(be.id));
            chk("bresp", DW'(s_axi_bresp), DW'(be.resp));
          end
        end
        if (s_axi_rvalid && s_axi_rready) begin
          if (rq.size() == 0) begin
            tests++; fails++;
            $display("FAIL r_unexpected: got rid %0h rresp %0b, required no beat", s_axi_rid, s_axi_rresp);
          end else begin
            re = rq.pop_front();
            chk("rid", DW'(s_axi_rid), DW'(re.id));
            chk("rdata", s_axi_rdata, re.data);
            chk("rresp", DW'(s_axi_rresp), DW'(re.resp));
            chk("rlast", DW'(s_axi_rlast), DW'(re.last));
          end
        end
        if (r_stall) begin
          chk("r_hold_ctl", DW'({s_axi_rvalid, s_axi_rlast, s_axi_rresp, s_axi_rid}), DW'(snap_ctl));
          chk("r_hold_data", s_axi_rdata, snap_data);
        end
        r_stall   = s_axi_rvalid && !s_axi_rready;
        snap_ctl  = {s_axi_rvalid, s_axi_rlast, s_axi_rresp, s_axi_rid};
        snap_data = s_axi_rdata;
      end
    end
  end

  // rready driver.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0: s_axi_rready = 1'b1;
        1: s_axi_rready = ~s_axi_rready;
        default: s_axi_rready = 1'b0;
      endcase
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All stimulus tasks start and end at posedge+#1.
  task automatic do_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
    int n = 0;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!s_axi_awready && n < 100);
    if (!s_axi_awready) begin
      tests++; fails++;
      $display("FAIL aw_timeout: got awready 0, required 1");
    end
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [DW-1:0] data, input logic [DW/8-1:0] strb,
                        input logic last, input logic fin);
    int n = 0;
    s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!s_axi_wready && n < 100);
    if (!s_axi_wready) begin
      tests++; fails++;
      $display("FAIL w_timeout: got wready 0, required 1");
    end
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    if (fin) begin
      chk("wready_after_last", DW'(s_axi_wready), DW'(0));
      chk("bvalid_next_cycle", DW'(s_axi_bvalid), DW'(1));
    end
  endtask

  task automatic do_wburst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input int len, input int base);
    push_b(id, 2'b00);
    do_aw(id, addr, 8'(len));
    for (int i = 0; i <= len; i++) w_beat(pat(base + i), '1, (i == len), (i == len));
  endtask

  task automatic do_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
    int n = 0;
    int lat = 0;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!s_axi_arready && n < 100);
    if (!s_axi_arready) begin
      tests++; fails++;
      $display("FAIL ar_timeout: got arready 0, required 1");
    end
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (s_axi_rvalid) begin lat = k; break; end
    end
    chk("rd_latency", DW'(lat), DW'(4));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 3000) begin
      @(posedge clk); n++;
    end
    #1;
    tests++;
    if (bq.size() != 0 || rq.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d B and %0d R pending, required 0", bq.size(), rq.size());
      bq.delete(); rq.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", DW'(s_axi_awready), DW'(1));
    chk("rst_arready", DW'(s_axi_arready), DW'(1));
    chk("rst_wready", DW'(s_axi_wready), DW'(0));
    chk("rst_bvalid", DW'(s_axi_bvalid), DW'(0));
    chk("rst_rvalid", DW'(s_axi_rvalid), DW'(0));
    chk("rst_rlast", DW'(s_axi_rlast), DW'(0));
    chk("rst_ids_resps", DW'({s_axi_bid, s_axi_rid, s_axi_bresp, s_axi_rresp}), DW'(0));
    chk("rst_rdata", s_axi_rdata, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: single beat write and read, latency
    push_b(16'h0001, 2'b00);
    do_aw(16'h0001, 64'h0, 8'd0);
    w_beat(DW'(32'hdeadbeef), '1, 1'b1, 1'b1);
    wait_drain();
    push_r(16'h0002, DW'(32'hdeadbeef), 2'b00, 1'b1);
    do_ar(16'h0002, 64'h0, 8'd0);
    wait_drain();

    // 2: 256-beat burst, readback with rready toggling
    do_wburst(16'h0010, 64'h10000, 255, 0);
    wait_drain();
    for (int i = 0; i < 256; i++) push_r(16'h0011, pat(i), 2'b00, (i == 255));
    rr_mode = 1;
    do_ar(16'h0011, 64'h10000, 8'd255);
    wait_drain();
    rr_mode = 0;

    // 3: partial strobe write
    push_b(16'h0003, 2'b00);
    do_aw(16'h0003, 64'h200, 8'd0);
    w_beat('1, '1, 1'b1, 1'b1);
    push_b(16'h0003, 2'b00);
    do_aw(16'h0003, 64'h200, 8'd0);
    w_beat('0, 64'hF, 1'b1, 1'b1);
    wait_drain();
    push_r(16'h0033, {{60{8'hFF}}, 32'h0}, 2'b00, 1'b1);
    do_ar(16'h0033, 64'h200, 8'd0);
    wait_drain();

    // 4: out-of-range DECERR, line 0 untouched, wlast mismatch SLVERR
    push_b(16'h0004, 2'b11);
    do_aw(16'h0004, 64'h40000, 8'd0);
    w_beat('1, '1, 1'b1, 1'b1);
    wait_drain();
    push_r(16'h0005, '0, 2'b11, 1'b0);
    push_r(16'h0005, '0, 2'b11, 1'b1);
    do_ar(16'h0005, 64'h40000, 8'd1);
    wait_drain();
    push_r(16'h0006, DW'(32'hdeadbeef), 2'b00, 1'b1);
    do_ar(16'h0006, 64'h0, 8'd0);
    wait_drain();
    push_b(16'h0007, 2'b10);
    do_aw(16'h0007, 64'h80, 8'd1);
    w_beat(pat(77), '1, 1'b1, 1'b0);
    w_beat(pat(78), '1, 1'b0, 1'b1);
    wait_drain();

    // 5: index wrap past the last line
    do_wburst(16'h0008, 64'h3FFC0, 3, 'h500);
    wait_drain();
    push_r(16'h0009, pat('h501), 2'b00, 1'b0);
    push_r(16'h0009, pat('h502), 2'b00, 1'b1);
    do_ar(16'h0009, 64'h0, 8'd1);
    wait_drain();
    push_r(16'h000A, pat('h500), 2'b00, 1'b1);
    do_ar(16'h000A, 64'h3FFC0, 8'd0);
    wait_drain();

    // 6: concurrent bursts
    fork
      do_wburst(16'h0060, 64'h1000, 3, 'h600);
      begin
        for (int i = 0; i < 4; i++) push_r(16'h0061, pat(i), 2'b00, (i == 3));
        do_ar(16'h0061, 64'h10000, 8'd3);
      end
    join
    wait_drain();
    for (int i = 0; i < 4; i++) push_r(16'h0062, pat('h600 + i), 2'b00, (i == 3));
    do_ar(16'h0062, 64'h1000, 8'd3);
    wait_drain();

    // 6: reset during a stalled read and a partial write burst
    rr_mode = 2;
    do_ar(16'h0077, 64'h10000, 8'd7);
    do_aw(16'h0070, 64'h2000, 8'd7);
    w_beat(pat('h700), '1, 1'b0, 1'b0);
    w_beat(pat('h701), '1, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rr_mode = 0;
    chk("abort_awready", DW'(s_axi_awready), DW'(1));
    chk("abort_arready", DW'(s_axi_arready), DW'(1));
    chk("abort_wready", DW'(s_axi_wready), DW'(0));
    chk("abort_bvalid", DW'(s_axi_bvalid), DW'(0));
    chk("abort_rvalid", DW'(s_axi_rvalid), DW'(0));
    repeat (10) @(posedge clk);
    #1;
    do_wburst(16'h0090, 64'h3000, 0, 'h900);
    wait_drain();
    push_r(16'h0091, pat('h900), 2'b00, 1'b1);
    do_ar(16'h0091, 64'h3000, 8'd0);
    wait_drain();
    push_r(16'h0092, pat('h700), 2'b00, 1'b0);
    push_r(16'h0092, pat('h701), 2'b00, 1'b1);
    do_ar(16'h0092, 64'h2000, 8'd1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
